clk_en_bank: RTL and testbench

//  Multi-channel fractional clock-enable generator for the core clock domain. Runs on one fast PLL output.

---
 rtl/clk_en_pkg.sv | 9 +
 rtl/clk_en_bank_ch.sv | 68 ++++++
 rtl/clk_en_bank.sv | 87 ++++++++
 tb/tb_clk_en_bank.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared state encoding and packed per-channel field access for clk_en_bank.
package clk_en_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} cen_state_e;
    localparam int unsigned MAX_W = 64;
    localparam int unsigned MAX_VEC = 1024;
    function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_VEC-1:0] vec, input int unsigned i, input int unsigned w);
        return MAX_W'(vec >> (i * w)) & ~({MAX_W{1'b1}} << w);
    endfunction
endpackage

// File: rtl/clk_en_bank_ch.sv
// clk_en_bank_ch: one fractional num/den accumulator channel of clk_en_bank.
// CLK_EN_BANK_PHASE_EN adds a phase shadow that seeds the accumulator on load and RUN entry.
module clk_en_bank_ch #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [ACC_W-1:0] num,
    input  logic [ACC_W-1:0] den,
`ifdef CLK_EN_BANK_PHASE_EN
    input  logic [ACC_W-1:0] phase,
`endif
    output logic             cen,
    output logic             err
);
    logic [ACC_W-1:0] num_q, num_d, den_q, den_d, acc_q, acc_d, init_acc, load_acc;
    logic [ACC_W:0]   sum;
    logic             cen_q, cen_d, err_q, err_d, live;
`ifdef CLK_EN_BANK_PHASE_EN
    logic [ACC_W-1:0] ph_q, ph_d;
    assign init_acc = den_q == '0 ? '0 : ph_q % den_q;
    assign load_acc = den == '0 ? '0 : phase % den;
`else
    assign init_acc = '0;
    assign load_acc = '0;
`endif
    assign sum  = {1'b0, acc_q} + {1'b0, num_q};
    // Saturated (num>=den) and disabled channels keep acc parked at its start value.
    assign live = run && den_q != '0 && num_q < den_q;
    assign cen  = cen_q;
    assign err  = err_q;

    always_comb begin
        num_d = load ? num : num_q;
        den_d = load ? den : den_q;
        err_d = load ? (den != '0 && num >= den) : err_q;
        acc_d = load ? load_acc : !live ? init_acc :
                sum >= {1'b0, den_q} ? ACC_W'(sum - {1'b0, den_q}) : sum[ACC_W-1:0];
        cen_d = !load && run && den_q != '0 && (num_q >= den_q || sum >= {1'b0, den_q});
`ifdef CLK_EN_BANK_PHASE_EN
        ph_d  = load ? phase : ph_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= '0;
            den_q <= '0;
            acc_q <= '0;
            cen_q <= 1'b0;
            err_q <= 1'b0;
`ifdef CLK_EN_BANK_PHASE_EN
            ph_q  <= '0;
`endif
        end else begin
            num_q <= num_d;
            den_q <= den_d;
            acc_q <= acc_d;
            cen_q <= cen_d;
            err_q <= err_d;
`ifdef CLK_EN_BANK_PHASE_EN
            ph_q  <= ph_d;
`endif
        end
    end
endmodule

// File: rtl/clk_en_bank.sv
// clk_en_bank: NCH fractional clock enables gated by a synchronised, settled PLL lock.
// CLK_EN_BANK_PHASE_EN adds cfg_phase for fixed inter-channel skew.
module clk_en_bank #(
    parameter int NCH       = 3,
    parameter int ACC_W     = 16,
    parameter int LOCK_SYNC = 2,
    parameter int SETTLE    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 cfg_wr,
    input  logic [NCH*ACC_W-1:0] cfg_num,
    input  logic [NCH*ACC_W-1:0] cfg_den,
`ifdef CLK_EN_BANK_PHASE_EN
    input  logic [NCH*ACC_W-1:0] cfg_phase,
`endif
    output logic [NCH-1:0]       cen,
    output logic                 ready,
    output logic [NCH-1:0]       cfg_err
);
    import clk_en_pkg::*;
    localparam int CW = $clog2(SETTLE + 1);

    cen_state_e           state_q, state_d;
    logic [LOCK_SYNC-1:0] sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ready_q, ready_d, lk, run;

    assign lk    = sync_q[LOCK_SYNC-1];
    // Losing lock in RUN stops accumulation at the very next edge, before the state register catches up.
    assign run   = state_q == RUN && lk;
    assign ready = ready_q;

    always_comb begin
        sync_d  = {sync_q[LOCK_SYNC-2:0], pll_locked};
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = clk_en_pkg::SETTLE;
                    cnt_d   = '0;
                end
            end
            clk_en_pkg::SETTLE: begin
                if (!lk) state_d = WAIT_LOCK;
                else if (cnt_q == CW'(SETTLE - 1)) state_d = RUN;
                else cnt_d = cnt_q + CW'(1);
            end
            default: begin
                if (!lk) state_d = WAIT_LOCK;
            end
        endcase
        ready_d = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            sync_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_en_bank_ch #(.ACC_W(ACC_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .run   (run),
            .load  (cfg_wr),
            .num   (ACC_W'(ch_slice(MAX_VEC'(cfg_num), g, ACC_W))),
            .den   (ACC_W'(ch_slice(MAX_VEC'(cfg_den), g, ACC_W))),
`ifdef CLK_EN_BANK_PHASE_EN
            .phase (ACC_W'(ch_slice(MAX_VEC'(cfg_phase), g, ACC_W))),
`endif
            .cen   (cen[g]),
            .err   (cfg_err[g])
        );
    end
endmodule

// File: tb/tb_clk_en_bank.sv
// tb_clk_en_bank: table vectors, directed corner sequences and random traffic against a ratio-based model.
module tb_clk_en_bank;
    localparam int NCH = 3, W = 16, LS = 2, ST = 16;

    logic clk = 1'b0, rst_n = 1'b0, pll = 1'b0, cfg_wr = 1'b0;
    logic [NCH*W-1:0] cfg_num = '0, cfg_den = '0;
`ifdef CLK_EN_BANK_PHASE_EN
    logic [NCH*W-1:0] cfg_phase = '0;
`endif
    logic [NCH-1:0] cen, cfg_err;
    logic ready;

    always #5 clk = ~clk;

    clk_en_bank #(.NCH(NCH), .ACC_W(W), .LOCK_SYNC(LS), .SETTLE(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll),
        .cfg_wr     (cfg_wr),
        .cfg_num    (cfg_num),
        .cfg_den    (cfg_den),
`ifdef CLK_EN_BANK_PHASE_EN
        .cfg_phase  (cfg_phase),
`endif
        .cen        (cen),
        .ready      (ready),
        .cfg_err    (cfg_err)
    );

    int checks = 0, passed = 0, cyc = 0, s_cyc = 0;
    logic s_ready;
    logic [NCH-1:0] s_cen, s_err;

    // Model: lock seen through a LS-deep delay line; ready once lock held SETTLE+1 cycles;
    // each channel pulses when floor((phase + n*num)/den) steps, n = accumulated RUN cycles.
    bit lk_q[$];
    int streak;
    bit m_ready;
    bit m_cen[NCH], m_err[NCH];
    longint m_num[NCH], m_den[NCH], m_phr[NCH], m_n[NCH];

    typedef struct {int num; int den; int cycles; int pulses; int consec; int err;} vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic void model_reset();
        lk_q.delete();
        repeat (LS) lk_q.push_back(1'b0);
        streak = 0;
        m_ready = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_cen[c] = 0; m_err[c] = 0; m_num[c] = 0; m_den[c] = 0; m_phr[c] = 0; m_n[c] = 0;
        end
    endfunction

    function automatic bit pulse(input int c);
        longint p;
        if (m_den[c] == 0) return 1'b0;
        if (m_num[c] >= m_den[c]) return 1'b1;
        p = m_phr[c] % m_den[c];
        return ((p + m_n[c] * m_num[c]) / m_den[c]) != ((p + (m_n[c] - 1) * m_num[c]) / m_den[c]);
    endfunction

    task automatic set_ch(input int c, input int n, input int d, input int p);
        cfg_num[c*W +: W] = W'(n);
        cfg_den[c*W +: W] = W'(d);
`ifdef CLK_EN_BANK_PHASE_EN
        cfg_phase[c*W +: W] = W'(p);
`else
        if (p < 0) $display("negative phase ignored");
`endif
    endtask

    task automatic step();
        bit run;
        @(negedge clk);
        s_ready = ready; s_cen = cen; s_err = cfg_err; s_cyc = cyc;
        check("ready", longint'(ready), longint'(m_ready));
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("cen[%0d]", c), longint'(cen[c]), longint'(m_cen[c]));
            check($sformatf("cfg_err[%0d]", c), longint'(cfg_err[c]), longint'(m_err[c]));
        end
        run = m_ready && lk_q[0];
        for (int c = 0; c < NCH; c++) begin
            if (cfg_wr) begin
                m_num[c] = longint'(cfg_num[c*W +: W]);
                m_den[c] = longint'(cfg_den[c*W +: W]);
`ifdef CLK_EN_BANK_PHASE_EN
                m_phr[c] = longint'(cfg_phase[c*W +: W]);
`endif
                m_n[c] = 0; m_cen[c] = 0;
                m_err[c] = m_den[c] != 0 && m_num[c] >= m_den[c];
            end else if (run) begin
                m_n[c]++;
                m_cen[c] = pulse(c);
            end else begin
                m_n[c] = 0; m_cen[c] = 0;
            end
        end
        m_ready = streak >= ST + 1;
        void'(lk_q.pop_front());
        lk_q.push_back(pll);
        streak = lk_q[0] ? streak + 1 : 0;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic load();
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, f, d, cnt, cons, prev, strobe, nz;
        int pq[$];
        tbl[0] = '{2, 9, 900, 200, 0, 0};
        tbl[1] = '{1, 4, 40, 10, 0, 0};
        tbl[2] = '{3, 8, 80, 30, 0, 0};
        tbl[3] = '{5, 5, 20, 20, 19, 1};
        tbl[4] = '{7, 3, 10, 10, 9, 1};
        tbl[5] = '{3, 0, 20, 0, 0, 0};
        tbl[6] = '{0, 5, 20, 0, 0, 0};
        tbl[7] = '{2, 3, 30, 20, 10, 0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", longint'(ready), 0);
        check("rst_cen", longint'(cen), 0);
        check("rst_err", longint'(cfg_err), 0);

        // Lock from reset release, ch0 = 1/4.
        rst_n = 1'b1; pll = 1'b1; cyc = 0;
        set_ch(0, 1, 4, 0); set_ch(1, 2, 9, 0); set_ch(2, 0, 0, 0);
        load();
        r = -1; pq.delete();
        for (int i = 0; i < 60; i++) begin
            step();
            if (s_ready && r < 0) r = s_cyc;
            if (s_cen[0] && pq.size() < 3) pq.push_back(s_cyc - r);
        end
        check("ready_rise", r, ST + LS + 1);
        check("cen0_count", pq.size(), 3);
        foreach (pq[k]) check("cen0_offset", pq[k], 4 * (k + 1));

        // Table: ch1 ratio, pulse count, adjacency, error flag; ch0/ch2 randomised.
        foreach (tbl[k]) begin
            set_ch(0, $urandom_range(0, 14), $urandom_range(0, 12), $urandom_range(0, 20));
            set_ch(1, tbl[k].num, tbl[k].den, 0);
            set_ch(2, $urandom_range(0, 14), $urandom_range(0, 12), $urandom_range(0, 20));
            load();
            step();
            cnt = 0; cons = 0; prev = 0;
            for (int i = 0; i < tbl[k].cycles; i++) begin
                step();
                cnt += int'(s_cen[1]);
                cons += int'(prev != 0 && s_cen[1]);
                prev = int'(s_cen[1]);
            end
            check($sformatf("tbl%0d_pulses", k), cnt, tbl[k].pulses);
            check($sformatf("tbl%0d_consec", k), cons, tbl[k].consec);
            check($sformatf("tbl%0d_err", k), longint'(s_err[1]), tbl[k].err);
        end

        // Mid-run reload ch0 to 1/3: restart from the strobe.
        set_ch(0, 1, 4, 0); set_ch(1, 2, 9, 0); set_ch(2, 0, 0, 0);
        load();
        repeat (20) step();
        set_ch(0, 1, 3, 0);
        load();
        strobe = s_cyc; pq.delete();
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_cen[0]) pq.push_back(s_cyc - strobe);
        end
        check("reload_count", pq.size(), 3);
        foreach (pq[k]) check("reload_offset", pq[k], 4 + 3 * k);

        // Saturated ch2, then a 3-cycle lock drop and relock.
        set_ch(0, 1, 4, 0); set_ch(2, 5, 5, 0);
        load();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += int'(s_cen[2]);
        end
        check("sat_cen2", cnt, 29);
        check("sat_err2", longint'(s_err[2]), 1);
        pll = 1'b0; d = cyc;
        repeat (3) step();
        pll = 1'b1;
        f = -1; r = -1; nz = 0; pq.delete();
        for (int i = 0; i < 60; i++) begin
            step();
            if (!s_ready && f < 0) f = s_cyc;
            if (f >= 0 && r < 0 && s_ready) r = s_cyc;
            if (f >= 0 && r < 0 && s_cen != '0) nz++;
            if (r >= 0 && s_cen[0] && pq.size() < 1) pq.push_back(s_cyc - r);
        end
        check("drop_ready_fall", f - d, LS + 1);
        check("drop_cen_quiet", nz, 0);
        check("relock_ready_rise", r - d, 3 + LS + ST + 1);
        check("relock_first_cen0", pq.size() == 1 ? pq[0] : -1, 4);

        // Asynchronous reset mid-RUN.
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_ready", longint'(ready), 0);
        check("async_cen", longint'(cen), 0);
        check("async_err", longint'(cfg_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; cyc = 0;
        model_reset();
        r = -1; nz = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_ready && r < 0) r = s_cyc;
            if (s_cen != '0) nz++;
        end
        check("post_rst_ready_rise", r, ST + LS + 1);
        check("post_rst_no_cen", nz, 0);
`ifdef CLK_EN_BANK_PHASE_EN
        set_ch(0, 1, 4, 3); set_ch(1, 0, 0, 0); set_ch(2, 0, 0, 0);
        load();
        pll = 1'b0; d = cyc;
        repeat (3) step();
        pll = 1'b1;
        r = -1; pq.delete();
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_cyc - d > 3 && s_ready && r < 0) r = s_cyc;
            if (r >= 0 && s_cen[0] && pq.size() < 1) pq.push_back(s_cyc - r);
        end
        check("phase_first_cen0", pq.size() == 1 ? pq[0] : -1, 1);
`endif

        // Random traffic: reloads and lock glitches.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) pll = ~pll;
            if ($urandom_range(0, 24) == 0) begin
                for (int c = 0; c < NCH; c++)
                    set_ch(c, $urandom_range(0, 14), $urandom_range(0, 12), $urandom_range(0, 20));
                load();
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
